featuremap_pad_writer: RTL and testbench

Producer side of the per-channel feature-map FIFOs read by the `featuremap_conv2d_*` filter blocks. It takes an unpadded WIDTH×WIDTH row-major stream of 32-bit IEEE-754 words, inserts a one-pixel zero border, and writes the resulting (WIDTH+2)×(WIDTH+2) frame into one channel FIFO using a `wrreq`/`fifo_full` handshake. Eight instances, one per input channel, feed a filter bank. Frames repeat back-to-back without any software intervention.

---
 rtl/featuremap_pad_writer.sv | 77 +++++++
 tb/tb_featuremap_pad_writer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/featuremap_pad_writer.sv
// Zero-border pad writer: turns an unpadded WIDTH x WIDTH row-major stream into
// back-to-back (WIDTH+2) x (WIDTH+2) frames pushed into a channel FIFO.
module featuremap_pad_writer #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned WIDTH      = 56
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  valid_in,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic                  in_ready,
   input  logic                  fifo_full,
   output logic                  wrreq,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  frame_done
);

   localparam int unsigned CW = $clog2(WIDTH + 2);
   localparam logic [CW-1:0] LAST = CW'(WIDTH + 1);

   typedef enum logic {PAD = 1'b0, DATA = 1'b1} state_t;

   state_t        r_state;
   logic [CW-1:0] r_row;
   logic [CW-1:0] r_col;
   logic          r_last;

   logic [CW-1:0] w_row_nxt;
   logic [CW-1:0] w_col_nxt;
   logic          w_at_eol;
   logic          w_nxt_data;
   logic          w_adv;
   logic          w_fire;

   // Next padded position and its class, registered alongside the counters
   always_comb begin
      w_at_eol  = (r_col == LAST);
      w_col_nxt = w_at_eol ? '0 : r_col + CW'(1);
      w_row_nxt = r_row;
      if (w_at_eol) begin
         w_row_nxt = (r_row == LAST) ? '0 : r_row + CW'(1);
      end
      w_nxt_data = (w_row_nxt != '0) && (w_row_nxt != LAST) &&
                   (w_col_nxt != '0) && (w_col_nxt != LAST);
   end

   assign w_adv    = !wrreq || !fifo_full;
   assign in_ready = w_adv && (r_state == DATA);
   assign w_fire   = w_adv && ((r_state == PAD) || valid_in);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= PAD;
         r_row      <= '0;
         r_col      <= '0;
         r_last     <= 1'b0;
         wrreq      <= 1'b0;
         data_out   <= '0;
         frame_done <= 1'b0;
      end else begin
         // r_last marks that the pending word is position (WIDTH+1, WIDTH+1)
         frame_done <= wrreq && !fifo_full && r_last;
         if (w_fire) begin
            wrreq    <= 1'b1;
            data_out <= (r_state == DATA) ? data_in : '0;
            r_last   <= (r_row == LAST) && w_at_eol;
            r_row    <= w_row_nxt;
            r_col    <= w_col_nxt;
            r_state  <= w_nxt_data ? DATA : PAD;
         end else if (w_adv) begin
            wrreq  <= 1'b0;
            r_last <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_featuremap_pad_writer.sv
// Directed bench for featuremap_pad_writer: WIDTH=4 scenarios plus a WIDTH=56 frame.
module tb_featuremap_pad_writer;

   localparam int unsigned W  = 4;
   localparam int unsigned P  = W + 2;
   localparam int unsigned N  = P * P;
   localparam int unsigned BW = 56;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, valid_in, fifo_full, in_ready, wrreq, frame_done;
   logic [31:0] data_in, data_out;
   logic        rst_b, valid_b, fifo_full_b, in_ready_b, wrreq_b, frame_done_b;
   logic [31:0] data_in_b, data_out_b;

   featuremap_pad_writer #(.DATA_WIDTH(32), .WIDTH(W)) dut_a (
      .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in),
      .in_ready(in_ready), .fifo_full(fifo_full), .wrreq(wrreq),
      .data_out(data_out), .frame_done(frame_done));

   featuremap_pad_writer #(.DATA_WIDTH(32), .WIDTH(BW)) dut_b (
      .clk(clk), .rst(rst_b), .valid_in(valid_b), .data_in(data_in_b),
      .in_ready(in_ready_b), .fifo_full(fifo_full_b), .wrreq(wrreq_b),
      .data_out(data_out_b), .frame_done(frame_done_b));

   // 1.0 .. 16.0 in IEEE-754 single precision
   logic [31:0] px [16] = '{
      32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
      32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
      32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
      32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000};

   int   total = 0;
   int   bad   = 0;
   int   src_idx, wr_cnt, fd_cnt, bubbles, cyc_n, last_fd_cyc;
   logic exp_fd;

   function automatic logic border(input int p);
      int r, c;
      r = p / P;
      c = p % P;
      return (r == 0) || (r == P - 1) || (c == 0) || (c == P - 1);
   endfunction

   function automatic logic [31:0] exp_word(input int p);
      int r, c;
      r = p / P;
      c = p % P;
      if (border(p)) return 32'h0;
      return px[(r - 1) * W + (c - 1)];
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; leaves the bench at a negedge with reset released
   task automatic reset_a();
      rst       = 1'b0;
      valid_in  = 1'b0;
      fifo_full = 1'b0;
      #1;
      check("rst_wrreq", 32'(wrreq), 32'd0);
      check("rst_data_out", data_out, 32'd0);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      repeat (2) @(negedge clk);
      rst         = 1'b1;
      src_idx     = 0;
      wr_cnt      = 0;
      exp_fd      = 1'b0;
      fd_cnt      = 0;
      bubbles     = 0;
      cyc_n       = 0;
      last_fd_cyc = 0;
   endtask

   // One clock: drive at negedge, check, then account for what the posedge does
   task automatic cycle(input logic v, input logic ff);
      logic wr, acc;
      valid_in  = v;
      fifo_full = ff;
      data_in   = px[src_idx];
      #1;
      check("in_ready", 32'(in_ready),
            32'((!wrreq || !fifo_full) && !border((wr_cnt + int'(wrreq)) % N)));
      check("frame_done", 32'(frame_done), 32'(exp_fd));
      if (frame_done) begin
         fd_cnt++;
         if (fd_cnt > 1) check("fd_spacing", 32'(cyc_n - last_fd_cyc), 32'(N));
         last_fd_cyc = cyc_n;
      end
      wr  = wrreq && !fifo_full;
      acc = valid_in && in_ready;
      if (wr) check("data_out", data_out, exp_word(wr_cnt % N));
      if (wr_cnt > 0 && !wrreq) bubbles++;
      exp_fd = wr && ((wr_cnt % N) == N - 1);
      @(posedge clk);
      if (acc) src_idx = (src_idx + 1) % 16;
      if (wr) wr_cnt++;
      cyc_n++;
      @(negedge clk);
   endtask

   task automatic run_until(input int target, input logic rnd, input int budget);
      int n;
      n = 0;
      while (wr_cnt < target && n < budget) begin
         cycle(rnd ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0);
         n++;
      end
      check("write_budget", 32'(wr_cnt), 32'(target));
   endtask

   initial begin
      logic [31:0] held;
      int nw, nd, first_data, k;
      rst = 1'b0; valid_in = 1'b0; fifo_full = 1'b0; data_in = '0;
      rst_b = 1'b0; valid_b = 1'b0; fifo_full_b = 1'b0; data_in_b = '0;
      repeat (2) @(negedge clk);

      // Streaming, three frames back-to-back
      reset_a();
      cycle(1'b1, 1'b0);
      check("first_pad_wrreq", 32'(wrreq), 32'd1);
      check("first_pad_data", data_out, 32'd0);
      run_until(3 * N, 1'b0, 200);
      cycle(1'b1, 1'b0);
      check("stream_fd_count", 32'(fd_cnt), 32'd3);
      check("stream_bubbles", 32'(bubbles), 32'd0);

      // Random upstream stalls
      reset_a();
      run_until(N, 1'b1, 600);
      cycle(1'b1, 1'b0);
      check("rand_fd_count", 32'(fd_cnt), 32'd1);

      // FIFO full while a data word is pending
      reset_a();
      run_until(8, 1'b0, 50);
      held = data_out;
      check("pending_word", held, exp_word(8));
      repeat (5) begin
         cycle(1'b1, 1'b1);
         check("hold_data", data_out, held);
         check("hold_wrreq", 32'(wrreq), 32'd1);
      end
      run_until(N, 1'b0, 100);
      cycle(1'b1, 1'b0);
      check("full_fd_count", 32'(fd_cnt), 32'd1);

      // Reset in row 2, then a clean frame
      reset_a();
      run_until(14, 1'b0, 50);
      reset_a();
      cycle(1'b1, 1'b0);
      check("rerst_pad_wrreq", 32'(wrreq), 32'd1);
      check("rerst_pad_data", data_out, 32'd0);
      run_until(N, 1'b0, 100);
      cycle(1'b1, 1'b0);
      check("rerst_fd_count", 32'(fd_cnt), 32'd1);

      // WIDTH=56 full frame
      rst_b = 1'b1; valid_b = 1'b1; fifo_full_b = 1'b0;
      nw = 0; nd = 0; first_data = 0; k = 0;
      for (int n = 0; n < 3500 && nw < (BW + 2) * (BW + 2); n++) begin
         logic wr, acc;
         data_in_b = 32'h1000 + 32'(k);
         #1;
         wr  = wrreq_b && !fifo_full_b;
         acc = valid_b && in_ready_b;
         if (wr) begin
            nw++;
            if (data_out_b != 32'h0) begin
               nd++;
               if (first_data == 0) begin
                  first_data = nw;
                  check("b_first_value", data_out_b, 32'h1000);
               end
            end
         end
         @(posedge clk);
         if (acc) k++;
         @(negedge clk);
      end
      #1;
      check("b_writes", 32'(nw), 32'd3364);
      check("b_data_writes", 32'(nd), 32'd3136);
      check("b_first_data_idx", 32'(first_data), 32'd60);
      check("b_frame_done", 32'(frame_done_b), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
